// File: rtl/rv32i_pkg.sv
// rv32i_pkg: opcode/funct constants, ALU op enum and ALU helpers
// shared by the rv32i_soc core and its sub-modules.
package rv32i_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    // SUB only exists in register form; bit 30 of an ADDI is immediate.
    function automatic alu_op_e alu_decode(logic [2:0] f3, logic alt,
                                           logic is_reg);
        case (f3)
            F3_ADD:  return (is_reg && alt) ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [31:0] alu_exec(alu_op_e op, logic [31:0] a,
                                             logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << sh;
            ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'd0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return $unsigned($signed(a) >>> sh);
            ALU_OR:   return a | b;
            default:  return a & b;
        endcase
    endfunction

    function automatic logic br_taken(logic [2:0] f3, logic [31:0] a,
                                      logic [31:0] b);
        case (f3)
            F3_BEQ:  return a == b;
            F3_BNE:  return a != b;
            F3_BLT:  return $signed(a) < $signed(b);
            F3_BGE:  return $signed(a) >= $signed(b);
            F3_BLTU: return a < b;
            F3_BGEU: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/regs.sv
// regs: 32x32 register file, two combinational reads, one write.
// x0 is never written, so it always reads zero.
module regs (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_we,
    input  logic [4:0]  i_rd_addr,
    input  logic [31:0] i_rd_data,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data
);

    logic [31:0] regs [0:31];

    assign o_rs1_data = regs[i_rs1_addr];
    assign o_rs2_data = regs[i_rs2_addr];

    // Clear on reset, otherwise write back the retiring result
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (i_we && i_rd_addr != 5'd0) begin
            regs[i_rd_addr] <= i_rd_data;
        end
    end

endmodule

// File: rtl/rom.sv
// rom: instruction ROM, combinational word read.
// Contents are preloaded into rom_mem from outside the design.
module rom #(
    parameter int ROM_DEPTH = 4096
) (
    input  logic [$clog2(ROM_DEPTH)-1:0] i_idx,
    output logic [31:0]                  o_data
);

    logic [31:0] rom_mem [0:ROM_DEPTH-1];

    assign o_data = rom_mem[i_idx];

endmodule

// File: rtl/rv32i_soc_core.sv
// rv32i_soc_core: single-cycle decode, ALU, branch and next-PC logic.
// SOC_DATA_RAM_EN adds a word-organised data RAM for loads/stores.
module rv32i_soc_core
    import rv32i_pkg::*;
#(
    parameter int ROM_DEPTH = 4096,
    parameter int RAM_DEPTH = 1024
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [31:0]                  i_instr,
    output logic [$clog2(ROM_DEPTH)-1:0] o_rom_idx
);

    logic [31:0] r_pc;
    logic [6:0]  w_op;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [2:0]  w_f3;
    logic        w_alt;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_res;
    logic [31:0] w_load_data;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_jalr_sum;
    logic [31:0] w_next_pc;
    logic [31:0] w_wdata;
    logic        w_we;
    alu_op_e     w_alu_op;

    assign w_op  = i_instr[6:0];
    assign w_rd  = i_instr[11:7];
    assign w_f3  = i_instr[14:12];
    assign w_rs1 = i_instr[19:15];
    assign w_rs2 = i_instr[24:20];
    assign w_alt = i_instr[30];

    assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_b = {{20{i_instr[31]}}, i_instr[7],
                      i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u = {i_instr[31:12], 12'd0};
    assign w_imm_j = {{12{i_instr[31]}}, i_instr[19:12],
                      i_instr[20], i_instr[30:21], 1'b0};

    assign o_rom_idx = r_pc[$clog2(ROM_DEPTH)+1:2];

    regs m_regs (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_we       (w_we),
        .i_rd_addr  (w_rd),
        .i_rd_data  (w_wdata),
        .i_rs1_addr (w_rs1),
        .i_rs2_addr (w_rs2),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data)
    );

    assign w_alu_b    = (w_op == OP_REG) ? w_rs2_data : w_imm_i;
    assign w_alu_op   = alu_decode(w_f3, w_alt, w_op == OP_REG);
    assign w_alu_res  = alu_exec(w_alu_op, w_rs1_data, w_alu_b);
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_jalr_sum = w_rs1_data + w_imm_i;

    if (RAM_DEPTH < 1) begin : g_bad_ram_depth
        $error("RAM_DEPTH must be positive");
    end

`ifdef SOC_DATA_RAM_EN
    localparam int RAM_AW = $clog2(RAM_DEPTH);

    logic [31:0]       r_ram [0:RAM_DEPTH-1];
    logic [31:0]       w_imm_s;
    logic [31:0]       w_mem_addr;
    logic [31:0]       w_mem_word;
    logic [31:0]       w_st_data;
    logic [3:0]        w_st_mask;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;

    assign w_imm_s    = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_mem_addr = w_rs1_data +
                        ((w_op == OP_STORE) ? w_imm_s : w_imm_i);
    assign w_ram_idx  = w_mem_addr[RAM_AW+1:2];
    assign w_mem_word = r_ram[w_ram_idx];
    assign w_byte     = w_mem_word[{w_mem_addr[1:0], 3'b000} +: 8];
    assign w_half     = w_mem_word[{w_mem_addr[1], 4'b0000} +: 16];

    // Sign/zero-extend the addressed lane of the RAM word
    always_comb begin
        w_load_data = w_mem_word;
        unique case (w_f3)
            F3_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   w_load_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  w_load_data = {24'd0, w_byte};
            F3_LHU:  w_load_data = {16'd0, w_half};
            default: w_load_data = w_mem_word;
        endcase
    end

    // Replicate store data across lanes and pick the byte enables
    always_comb begin
        w_st_data = w_rs2_data;
        w_st_mask = 4'b1111;
        unique case (w_f3[1:0])
            2'b00: begin
                w_st_data = {4{w_rs2_data[7:0]}};
                w_st_mask = 4'b0001 << w_mem_addr[1:0];
            end
            2'b01: begin
                w_st_data = {2{w_rs2_data[15:0]}};
                w_st_mask = w_mem_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Byte-masked synchronous store; RAM contents survive reset
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_op == OP_STORE) begin
            for (int k = 0; k < 4; k++) begin
                if (w_st_mask[k]) begin
                    r_ram[w_ram_idx][8*k +: 8] <= w_st_data[8*k +: 8];
                end
            end
        end
    end
`else
    assign w_load_data = '0;
`endif

    // Pick the write-back value and the next PC from the opcode
    always_comb begin
        w_we      = 1'b0;
        w_wdata   = w_alu_res;
        w_next_pc = w_pc_plus4;
        unique case (w_op)
            OP_LUI: begin
                w_we    = 1'b1;
                w_wdata = w_imm_u;
            end
            OP_AUIPC: begin
                w_we    = 1'b1;
                w_wdata = r_pc + w_imm_u;
            end
            OP_JAL: begin
                w_we      = 1'b1;
                w_wdata   = w_pc_plus4;
                w_next_pc = r_pc + w_imm_j;
            end
            OP_JALR: begin
                w_we      = 1'b1;
                w_wdata   = w_pc_plus4;
                w_next_pc = {w_jalr_sum[31:1], 1'b0};
            end
            OP_BRANCH: begin
                if (br_taken(w_f3, w_rs1_data, w_rs2_data)) begin
                    w_next_pc = r_pc + w_imm_b;
                end
            end
            OP_LOAD: begin
                w_we    = 1'b1;
                w_wdata = w_load_data;
            end
            OP_IMM, OP_REG: begin
                w_we = 1'b1;
            end
            default: ;
        endcase
    end

    // Program counter: one instruction retires per clock
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_next_pc;
        end
    end

endmodule

// File: rtl/rv32i_soc.sv
// rv32i_soc: single-cycle RV32I system - instruction ROM plus core.
// Define SOC_DATA_RAM_EN to give loads/stores a real data RAM.
module rv32i_soc #(
    parameter int ROM_DEPTH = 4096,
    parameter int RAM_DEPTH = 1024
) (
    input logic clk,
    input logic rst
);

    logic [31:0]                  w_instr;
    logic [$clog2(ROM_DEPTH)-1:0] w_rom_idx;

    rom #(
        .ROM_DEPTH (ROM_DEPTH)
    ) m_rom (
        .i_idx  (w_rom_idx),
        .o_data (w_instr)
    );

    rv32i_soc_core #(
        .ROM_DEPTH (ROM_DEPTH),
        .RAM_DEPTH (RAM_DEPTH)
    ) top (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_instr   (w_instr),
        .o_rom_idx (w_rom_idx)
    );

endmodule

// File: tb/tb_rv32i_soc.sv
// tb_rv32i_soc: table-driven programs with a per-retire scoreboard
// on register and PC state of rv32i_soc.
module tb_rv32i_soc;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rv32i_soc #(
        .ROM_DEPTH (4096),
        .RAM_DEPTH (1024)
    ) dut (
        .clk (clk),
        .rst (rst)
    );

    typedef struct {
        string       name;
        logic [31:0] instr;
        int          rd;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        int          rd;
        logic [31:0] exp;
        logic [31:0] pc;
    } step_t;

    int          checks = 0;
    int          errors = 0;
    step_t       sb[$];
    logic [31:0] img [0:63];
    step_t       st  [0:63];
    int          n_img;
    int          n_st;
    vec_t        va  [0:26];

    function automatic logic [31:0] enc_i(int op, int f3, int rd, int rs1,
                                          int imm);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_r(int f7, int f3, int rd, int rs1,
                                          int rs2);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_sh(int f7, int f3, int rd, int rs1,
                                           int sh);
        return {f7[6:0], sh[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h13};
    endfunction

    function automatic logic [31:0] enc_s(int f3, int rs2, int rs1, int imm);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(int f3, int rs1, int rs2, int imm);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0],
                imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(int op, int rd, int imm);
        return {imm[19:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_j(int rd, int imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
    endfunction

    function automatic logic [31:0] addi(int rd, int rs1, int imm);
        return enc_i(7'h13, 0, rd, rs1, imm);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic load_rom();
        for (int i = 0; i < 4096; i++) dut.m_rom.rom_mem[i] = 32'h0000_0013;
        for (int i = 0; i < n_img; i++) dut.m_rom.rom_mem[i] = img[i];
    endtask

    task automatic check_cleared(input string name);
        int nz;
        nz = 0;
        for (int i = 0; i < 32; i++) begin
            if (dut.top.m_regs.regs[i] !== 32'd0) nz++;
        end
        chk({name, "_regs"}, nz, 0);
        chk({name, "_pc"}, dut.top.r_pc, 32'd0);
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        #30;
        check_cleared(name);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_steps();
        step_t s;
        for (int i = 0; i < n_st; i++) sb.push_back(st[i]);
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            s = sb.pop_front();
            chk(s.name, dut.top.m_regs.regs[s.rd], s.exp);
            chk({s.name, "_pc"}, dut.top.r_pc, s.pc);
        end
    endtask

    task automatic add_step(input string name, input int rd,
                            input logic [31:0] exp, input logic [31:0] pc);
        st[n_st] = '{name, rd, exp, pc};
        n_st++;
    endtask

    initial begin
        logic done;

        // ALU / immediate vectors, straight-line code
        va[0]  = '{"addi_neg", addi(1, 0, -16), 1, 32'hFFFF_FFF0};
        va[1]  = '{"srai_2", enc_sh(7'h20, 5, 2, 1, 2), 2, 32'hFFFF_FFFC};
        va[2]  = '{"srai_31", enc_sh(7'h20, 5, 3, 1, 31), 3, 32'hFFFF_FFFF};
        va[3]  = '{"srli_28", enc_sh(7'h00, 5, 4, 1, 28), 4, 32'h0000_000F};
        va[4]  = '{"x0_write", addi(0, 0, 5), 0, 32'h0};
        va[5]  = '{"addi_m1", addi(6, 0, -1), 6, 32'hFFFF_FFFF};
        va[6]  = '{"addi_1", addi(7, 0, 1), 7, 32'h1};
        va[7]  = '{"slt", enc_r(0, 2, 8, 6, 7), 8, 32'h1};
        va[8]  = '{"sltu", enc_r(0, 3, 9, 6, 7), 9, 32'h0};
        va[9]  = '{"sub", enc_r(7'h20, 0, 10, 7, 6), 10, 32'h2};
        va[10] = '{"lui", enc_u(7'h37, 11, 'h80000), 11, 32'h8000_0000};
        va[11] = '{"add_wrap", enc_r(0, 0, 12, 11, 11), 12, 32'h0};
        va[12] = '{"sra", enc_r(7'h20, 5, 13, 11, 7), 13, 32'hC000_0000};
        va[13] = '{"srl", enc_r(0, 5, 14, 11, 7), 14, 32'h4000_0000};
        va[14] = '{"sll", enc_r(0, 1, 15, 6, 4), 15, 32'hFFFF_8000};
        va[15] = '{"auipc", enc_u(7'h17, 16, 1), 16, 32'h0000_103C};
        va[16] = '{"xori", enc_i(7'h13, 4, 17, 6, 'h0F0), 17, 32'hFFFF_FF0F};
        va[17] = '{"andi", enc_i(7'h13, 7, 18, 6, 'hF00), 18, 32'hFFFF_FF00};
        va[18] = '{"ori", enc_i(7'h13, 6, 19, 0, 'h555), 19, 32'h0000_0555};
        va[19] = '{"sltiu", enc_i(7'h13, 3, 20, 7, -1), 20, 32'h1};
        va[20] = '{"slti", enc_i(7'h13, 2, 21, 6, 0), 21, 32'h1};
        va[21] = '{"and", enc_r(0, 7, 22, 6, 19), 22, 32'h0000_0555};
        va[22] = '{"or", enc_r(0, 6, 23, 19, 11), 23, 32'h8000_0555};
        va[23] = '{"xor", enc_r(0, 4, 24, 23, 6), 24, 32'h7FFF_FAAA};
        va[24] = '{"ecall_nop", 32'h0000_0073, 0, 32'h0};
        va[25] = '{"sll_shamt5", enc_r(0, 1, 25, 7, 6), 25, 32'h8000_0000};
        va[26] = '{"add_self", enc_r(0, 0, 7, 7, 7), 7, 32'h2};

        // Reset with arbitrary ROM, then rom_mem[0] retires first
        for (int i = 0; i < 4096; i++) dut.m_rom.rom_mem[i] = $urandom;
        dut.m_rom.rom_mem[0] = addi(1, 0, 'h123);
        #30;
        check_cleared("por");
        repeat (2) @(posedge clk);
        #1;
        chk("por_hold_pc", dut.top.r_pc, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("first_retire", dut.top.m_regs.regs[1], 32'h0000_0123);
        chk("first_retire_pc", dut.top.r_pc, 32'd4);

        // ALU table
        n_img = 27;
        n_st  = 0;
        for (int i = 0; i < 27; i++) begin
            img[i] = va[i].instr;
            add_step(va[i].name, va[i].rd, va[i].exp, 32'(4 * (i + 1)));
        end
        load_rom();
        do_reset("rst_alu");
        run_steps();

        // Reset mid-program: async clear, pending write lost, ROM kept
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_cleared("midrst");
        @(posedge clk);
        #1;
        chk("midrst_no_write", dut.top.m_regs.regs[1], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_rerun", dut.top.m_regs.regs[1], 32'hFFFF_FFF0);
        chk("midrst_rerun_pc", dut.top.r_pc, 32'd4);

        // Branch / JAL / JALR
        img[0] = addi(5, 0, 3);
        img[1] = enc_b(0, 5, 5, 8);
        img[2] = addi(6, 0, 1);
        img[3] = addi(7, 0, 2);
        img[4] = enc_j(1, 8);
        img[5] = addi(8, 0, 9);
        img[6] = enc_i(7'h67, 0, 0, 1, 1);
        n_img  = 7;
        n_st   = 0;
        add_step("j_addi", 5, 32'd3, 32'h04);
        add_step("j_beq", 0, 32'd0, 32'h0C);
        add_step("j_after", 7, 32'd2, 32'h10);
        add_step("j_jal", 1, 32'h14, 32'h18);
        add_step("j_jalr", 0, 32'd0, 32'h14);
        add_step("j_land", 8, 32'd9, 32'h18);
        load_rom();
        do_reset("rst_jmp");
        run_steps();
        chk("j_skipped", dut.top.m_regs.regs[6], 32'd0);

        // Signed/unsigned branch variants and a backward branch
        img[0]  = addi(6, 0, -1);
        img[1]  = addi(7, 0, 1);
        img[2]  = enc_b(4, 6, 7, 8);
        img[3]  = addi(9, 0, 1);
        img[4]  = enc_b(6, 6, 7, 8);
        img[5]  = enc_b(5, 7, 6, 8);
        img[6]  = addi(9, 0, 1);
        img[7]  = enc_b(7, 7, 6, 8);
        img[8]  = enc_b(1, 6, 6, 8);
        img[9]  = enc_b(0, 6, 7, 8);
        img[10] = enc_b(1, 6, 7, -40);
        n_img   = 11;
        n_st    = 0;
        add_step("b_m1", 6, 32'hFFFF_FFFF, 32'h04);
        add_step("b_1", 7, 32'd1, 32'h08);
        add_step("b_blt", 0, 32'd0, 32'h10);
        add_step("b_bltu", 0, 32'd0, 32'h14);
        add_step("b_bge", 0, 32'd0, 32'h1C);
        add_step("b_bgeu", 0, 32'd0, 32'h20);
        add_step("b_bne_nt", 0, 32'd0, 32'h24);
        add_step("b_beq_nt", 0, 32'd0, 32'h28);
        add_step("b_bne_back", 0, 32'd0, 32'h00);
        add_step("b_rerun", 6, 32'hFFFF_FFFF, 32'h04);
        load_rom();
        do_reset("rst_br");
        run_steps();
        chk("b_skipped", dut.top.m_regs.regs[9], 32'd0);

        // Self-checking SRAI program using the x26/x27/x3 convention
        img[0]  = addi(3, 0, 2);
        img[1]  = enc_u(7'h37, 1, 'h80000);
        img[2]  = enc_sh(7'h20, 5, 14, 1, 1);
        img[3]  = enc_u(7'h37, 29, 'hC0000);
        img[4]  = enc_b(1, 14, 29, 'h34);
        img[5]  = addi(3, 0, 3);
        img[6]  = enc_sh(7'h20, 5, 14, 1, 31);
        img[7]  = addi(29, 0, -1);
        img[8]  = enc_b(1, 14, 29, 'h24);
        img[9]  = addi(3, 0, 4);
        img[10] = addi(1, 0, 'h7FF);
        img[11] = enc_sh(7'h20, 5, 14, 1, 4);
        img[12] = addi(29, 0, 'h7F);
        img[13] = enc_b(1, 14, 29, 'h10);
        img[14] = addi(27, 0, 1);
        img[15] = addi(26, 0, 1);
        img[16] = enc_j(0, 0);
        img[17] = addi(26, 0, 1);
        img[18] = enc_j(0, 0);
        n_img   = 19;
        load_rom();
        do_reset("rst_srai");
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(posedge clk);
            #1;
            if (dut.top.m_regs.regs[26] == 32'd1) done = 1'b1;
        end
        chk("srai_done", {31'd0, done}, 32'd1);
        #200;
        chk("srai_pass", dut.top.m_regs.regs[27], 32'd1);
        chk("srai_testnum", dut.top.m_regs.regs[3], 32'd4);

        // Loads and stores
        n_st = 0;
`ifdef SOC_DATA_RAM_EN
        img[0]  = enc_u(7'h37, 1, 'h80FF1);
        img[1]  = addi(1, 1, 'h234);
        img[2]  = addi(2, 0, 'h100);
        img[3]  = enc_s(2, 1, 2, 0);
        img[4]  = enc_i(7'h03, 0, 3, 2, 0);
        img[5]  = enc_i(7'h03, 0, 4, 2, 3);
        img[6]  = enc_i(7'h03, 5, 5, 2, 2);
        img[7]  = enc_i(7'h03, 1, 6, 2, 2);
        img[8]  = enc_i(7'h03, 4, 7, 2, 3);
        img[9]  = enc_s(0, 0, 2, 1);
        img[10] = enc_i(7'h03, 2, 8, 2, 0);
        img[11] = enc_s(1, 1, 2, 1);
        img[12] = enc_i(7'h03, 2, 9, 2, 0);
        n_img   = 13;
        add_step("m_lui", 1, 32'h80FF_1000, 32'h04);
        add_step("m_addi", 1, 32'h80FF_1234, 32'h08);
        add_step("m_base", 2, 32'h100, 32'h0C);
        add_step("m_sw", 0, 32'd0, 32'h10);
        add_step("m_lb0", 3, 32'h0000_0034, 32'h14);
        add_step("m_lb3", 4, 32'hFFFF_FF80, 32'h18);
        add_step("m_lhu2", 5, 32'h0000_80FF, 32'h1C);
        add_step("m_lh2", 6, 32'hFFFF_80FF, 32'h20);
        add_step("m_lbu3", 7, 32'h0000_0080, 32'h24);
        add_step("m_sb", 0, 32'd0, 32'h28);
        add_step("m_lw_sb", 8, 32'h80FF_0034, 32'h2C);
        add_step("m_sh_mis", 0, 32'd0, 32'h30);
        add_step("m_lw_sh", 9, 32'h80FF_1234, 32'h34);
`else
        img[0] = addi(2, 0, 'h100);
        img[1] = addi(3, 0, 7);
        img[2] = enc_s(2, 3, 2, 0);
        img[3] = enc_i(7'h03, 2, 3, 2, 0);
        img[4] = enc_i(7'h03, 4, 4, 3, 0);
        n_img  = 5;
        add_step("n_base", 2, 32'h100, 32'h04);
        add_step("n_seven", 3, 32'd7, 32'h08);
        add_step("n_sw_nop", 0, 32'd0, 32'h0C);
        add_step("n_lw_zero", 3, 32'd0, 32'h10);
        add_step("n_lbu_zero", 4, 32'd0, 32'h14);
`endif
        load_rom();
        do_reset("rst_mem");
        run_steps();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
